// File: rtl/result_ascii_sender_if.sv
// Handshake bundle between a result producer, the ASCII sender and a serial transmitter.
// Ports: value/start (request side), tx_rts (transmitter ready), tx_data/tx_data_ready
//        (byte launch toward the transmitter), busy/done (status back to the requester).
// slave modport is the sender's view; master modport is the environment's view.
interface result_ascii_sender_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] value;
  logic              start;
  logic              tx_rts;
  logic [7:0]        tx_data;
  logic              tx_data_ready;
  logic              busy;
  logic              done;

  modport slave (
    input  value, start, tx_rts,
    output tx_data, tx_data_ready, busy, done
  );

  modport master (
    output value, start, tx_rts,
    input  tx_data, tx_data_ready, busy, done
  );
endinterface

// File: rtl/result_ascii_sender.sv
// Purpose: print an unsigned DATA_W-bit result as decimal ASCII through a byte-wide serial transmitter.
// Latency: DATA_W conversion cycles after start, then one byte per transmitter frame; done one cycle after the last frame.
// Backpressure: every byte waits for tx_rts high before its strobe and for the frame to finish; no timeout.
//
// Ports:
//   clk            rising-edge system clock
//   rst            asynchronous active-high reset
//   bus (slave)    value/start in, tx_rts in, tx_data/tx_data_ready out, busy/done out
// Build option: define RESULT_CRLF_EN to append CR (0x0D) and LF (0x0A) after the digits.
module result_ascii_sender #(
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  result_ascii_sender_if.slave  bus
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CONVERT   = 3'd1;
  localparam logic [2:0] S_LOAD      = 3'd2;
  localparam logic [2:0] S_PULSE     = 3'd3;
  localparam logic [2:0] S_WAIT_BUSY = 3'd4;
  localparam logic [2:0] S_WAIT_DONE = 3'd5;
  localparam logic [2:0] S_FINISH    = 3'd6;

  // Byte index: 0..4 are BCD digits (MSD first), 5 is CR, 6 is LF.
`ifdef RESULT_CRLF_EN
  localparam logic [2:0] LAST_IDX = 3'd6;
`else
  localparam logic [2:0] LAST_IDX = 3'd4;
`endif

  localparam logic [4:0] LAST_BIT = 5'(DATA_W - 1);

  logic [2:0]        r_state;
  logic [DATA_W-1:0] r_shift;
  logic [19:0]       r_bcd;
  logic [4:0]        r_bit_cnt;
  logic [2:0]        r_dig_idx;
  logic [7:0]        r_tx_data;
  logic              r_tx_data_ready;
  logic              r_busy;
  logic              r_done;

  logic [19:0]       w_bcd_adj;
  logic [19:0]       w_bcd_nxt;
  logic [2:0]        w_first_idx;
  logic              w_found;
  logic [3:0]        w_digit;
  logic [7:0]        w_byte;

  // One double-dabble step: add 3 to any digit >= 5, then shift the next result bit in.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int d = 0; d < 5; d++) begin
      if (r_bcd[d*4 +: 4] >= 4'd5) begin
        w_bcd_adj[d*4 +: 4] = r_bcd[d*4 +: 4] + 4'd3;
      end
    end
    w_bcd_nxt = {w_bcd_adj[18:0], r_shift[DATA_W-1]};
  end

  // First non-zero digit of the finished conversion; the units digit is always sent,
  // which is how a zero result still prints "0".
  always_comb begin
    w_first_idx = 3'd4;
    w_found     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!w_found && (w_bcd_nxt[(4-i)*4 +: 4] != 4'd0)) begin
        w_first_idx = 3'(i);
        w_found     = 1'b1;
      end
    end
  end

  always_comb begin
    w_digit = 4'd0;
    case (r_dig_idx)
      3'd0:    w_digit = r_bcd[19:16];
      3'd1:    w_digit = r_bcd[15:12];
      3'd2:    w_digit = r_bcd[11:8];
      3'd3:    w_digit = r_bcd[7:4];
      3'd4:    w_digit = r_bcd[3:0];
      default: w_digit = 4'd0;
    endcase
    if (r_dig_idx <= 3'd4) begin
      w_byte = {4'h3, w_digit};
    end else if (r_dig_idx == 3'd5) begin
      w_byte = 8'h0D;
    end else begin
      w_byte = 8'h0A;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_shift         <= '0;
      r_bcd           <= '0;
      r_bit_cnt       <= '0;
      r_dig_idx       <= '0;
      r_tx_data       <= 8'h00;
      r_tx_data_ready <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      // Strobe and done are single-cycle by construction: cleared unless set below.
      r_tx_data_ready <= 1'b0;
      r_done          <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_shift   <= bus.value;
            r_bcd     <= '0;
            r_bit_cnt <= '0;
            r_busy    <= 1'b1;
            r_state   <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          r_bcd     <= w_bcd_nxt;
          r_shift   <= r_shift << 1;
          r_bit_cnt <= r_bit_cnt + 5'd1;
          if (r_bit_cnt == LAST_BIT) begin
            r_dig_idx <= w_first_idx;
            r_state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          // tx_data is written only here, so it holds through the whole frame.
          r_tx_data <= w_byte;
          r_state   <= S_PULSE;
        end
        S_PULSE: begin
          if (bus.tx_rts) begin
            r_tx_data_ready <= 1'b1;
            r_state         <= S_WAIT_BUSY;
          end
        end
        S_WAIT_BUSY: begin
          // The transmitter may still show ready on the cycle after the strobe;
          // only its drop to busy moves us on, never a second strobe.
          if (!bus.tx_rts) begin
            r_state <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (bus.tx_rts) begin
            if (r_dig_idx == LAST_IDX) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_FINISH;
            end else begin
              r_dig_idx <= r_dig_idx + 3'd1;
              r_state   <= S_LOAD;
            end
          end
        end
        S_FINISH: begin
          // done is visible in this cycle; a start here is deliberately not seen.
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.tx_data       = r_tx_data;
  assign bus.tx_data_ready = r_tx_data_ready;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;

endmodule

// File: tb/tb_result_ascii_sender.sv
// Bench for result_ascii_sender: vector table of values with their expected decimal text,
// a transmitter model that scores every strobed byte against a queue of expected bytes,
// and hand-written sequences for stall, overlapping start, done/start timing and reset.
module tb_result_ascii_sender;
  localparam int DATA_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  result_ascii_sender_if #(.DATA_W(DATA_W)) bus_if ();

  result_ascii_sender #(.DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int strobe_cnt = 0;
  int done_cnt   = 0;
  int n_msgs     = 0;
  int frame_cnt  = 0;
  bit auto_tx    = 1'b1;
  logic prev_rdy = 1'b0;
  logic [7:0] exp_q [$];

  typedef struct packed {
    logic [15:0] value;
    logic [39:0] ascii;  // expected digits, right-aligned, most significant digit first
    logic [3:0]  n;      // number of digit bytes
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Transmitter model: accepts a strobe only while idle, then stays busy for 4 cycles.
  initial begin : xmit_model
    logic [7:0] e_byte;
    forever begin
      @(negedge clk);
      if (bus_if.done === 1'b1) done_cnt++;
      if (bus_if.tx_data_ready === 1'b1) begin
        strobe_cnt++;
        if (prev_rdy === 1'b1) begin
          n_tests++; n_fail++;
          $display("FAIL strobe_back_to_back: got 2 consecutive strobes, expected 1");
        end
        if (bus_if.tx_rts !== 1'b1) begin
          n_tests++; n_fail++;
          $display("FAIL strobe_while_tx_busy: got strobe with tx_rts=%0b, expected tx_rts=1", bus_if.tx_rts);
        end
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_byte: got %0h, expected no byte", bus_if.tx_data);
        end else begin
          e_byte = exp_q.pop_front();
          check("tx_byte", {24'h0, bus_if.tx_data}, {24'h0, e_byte});
        end
        if (auto_tx) begin
          bus_if.tx_rts = 1'b0;
          frame_cnt = 4;
        end
      end else if (auto_tx && frame_cnt > 0) begin
        frame_cnt--;
        if (frame_cnt == 0) bus_if.tx_rts = 1'b1;
      end
      prev_rdy = bus_if.tx_data_ready;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic push_msg(input logic [39:0] ascii, input logic [3:0] n);
    for (int i = int'(n) - 1; i >= 0; i--) exp_q.push_back(ascii[i*8 +: 8]);
`ifdef RESULT_CRLF_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
  endtask

  task automatic start_msg(input logic [15:0] v);
    @(negedge clk);
    bus_if.value = v;
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    check("busy_after_start", {31'h0, bus_if.busy}, 32'h1);
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (bus_if.done === 1'b1) seen = 1'b1;
    end
    check(name, {31'h0, seen}, 32'h1);
    if (seen) begin
      n_msgs++;
      check("busy_low_with_done", {31'h0, bus_if.busy}, 32'h0);
      check("all_bytes_sent", exp_q.size(), 32'h0);
    end
  endtask

  task automatic wait_strobes(input int target, input string name);
    bit ok = 1'b0;
    for (int c = 0; c < 500 && !ok; c++) begin
      @(negedge clk);
      #1;
      if (strobe_cnt >= target) ok = 1'b1;
    end
    check(name, {31'h0, ok}, 32'h1);
  endtask

  initial begin : main
    int s0;
    bit stuck_ok;
    bit got;

    vecs[0] = '{value: 16'd1234,  ascii: 40'h0031323334, n: 4'd4};
    vecs[1] = '{value: 16'd0,     ascii: 40'h0000000030, n: 4'd1};
    vecs[2] = '{value: 16'd65535, ascii: 40'h3635353335, n: 4'd5};
    vecs[3] = '{value: 16'd7,     ascii: 40'h0000000037, n: 4'd1};
    vecs[4] = '{value: 16'd10,    ascii: 40'h0000003130, n: 4'd2};
    vecs[5] = '{value: 16'd100,   ascii: 40'h0000313030, n: 4'd3};
    vecs[6] = '{value: 16'd9,     ascii: 40'h0000000039, n: 4'd1};
    vecs[7] = '{value: 16'd40000, ascii: 40'h3430303030, n: 4'd5};
    vecs[8] = '{value: 16'd1000,  ascii: 40'h0031303030, n: 4'd4};
    vecs[9] = '{value: 16'd1,     ascii: 40'h0000000031, n: 4'd1};

    bus_if.value  = '0;
    bus_if.start  = 1'b0;
    bus_if.tx_rts = 1'b1;

    // Reset state, and a start held during reset must not be taken.
    #1 rst = 1'b1;
    #2;
    check("rst_tx_data", {24'h0, bus_if.tx_data}, 32'h0);
    check("rst_tx_data_ready", {31'h0, bus_if.tx_data_ready}, 32'h0);
    check("rst_busy", {31'h0, bus_if.busy}, 32'h0);
    check("rst_done", {31'h0, bus_if.done}, 32'h0);
    bus_if.value = 16'd5;
    bus_if.start = 1'b1;
    repeat (3) @(negedge clk);
    check("start_ignored_in_rst", {31'h0, bus_if.busy}, 32'h0);
    bus_if.start = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_after_rst", {31'h0, bus_if.busy}, 32'h0);

    // Table of values through an ideal transmitter.
    for (int k = 0; k < 10; k++) begin
      push_msg(vecs[k].ascii, vecs[k].n);
      start_msg(vecs[k].value);
      wait_done("done_vec", 400);
      @(negedge clk);
      check("done_one_cycle", {31'h0, bus_if.done}, 32'h0);
    end

    // Transmitter stuck busy: no strobe, busy held; release gives a prompt strobe.
    auto_tx = 1'b0;
    @(negedge clk);
    bus_if.tx_rts = 1'b0;
    push_msg(vecs[0].ascii, vecs[0].n);
    start_msg(16'd1234);
    stuck_ok = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (bus_if.tx_data_ready !== 1'b0 || bus_if.busy !== 1'b1) stuck_ok = 1'b0;
    end
    check("stall_no_strobe_busy_high", {31'h0, stuck_ok}, 32'h1);
    s0 = strobe_cnt;
    auto_tx = 1'b1;
    frame_cnt = 0;
    bus_if.tx_rts = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 2 && !got; c++) begin
      @(negedge clk);
      #1;
      if (strobe_cnt > s0) got = 1'b1;
    end
    check("release_strobe_within_2", {31'h0, got}, 32'h1);
    wait_done("done_after_stall", 400);

    // Start mid-message is ignored; start during done ignored; start one cycle later taken.
    push_msg(vecs[0].ascii, vecs[0].n);
    start_msg(16'd1234);
    s0 = strobe_cnt;
    wait_strobes(s0 + 2, "mid_msg_progress");
    bus_if.value = 16'd7;
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    wait_done("done_ignoring_mid_start", 400);
    bus_if.value = 16'd9;
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.value = 16'd7;
    push_msg(40'h0000000037, 4'd1);
    @(negedge clk);
    bus_if.start = 1'b0;
    check("busy_after_late_start", {31'h0, bus_if.busy}, 32'h1);
    wait_done("done_after_late_start", 400);

    // Reset during the third byte abandons the message.
    push_msg(vecs[0].ascii, vecs[0].n);
    start_msg(16'd1234);
    s0 = strobe_cnt;
    wait_strobes(s0 + 3, "third_byte_reached");
    rst = 1'b1;
    #1;
    check("midrst_tx_data", {24'h0, bus_if.tx_data}, 32'h0);
    check("midrst_tx_data_ready", {31'h0, bus_if.tx_data_ready}, 32'h0);
    check("midrst_busy", {31'h0, bus_if.busy}, 32'h0);
    check("midrst_done", {31'h0, bus_if.done}, 32'h0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    s0 = strobe_cnt;
    repeat (30) @(negedge clk);
    check("no_strobe_after_rst", strobe_cnt - s0, 32'h0);
    push_msg(vecs[0].ascii, vecs[0].n);
    start_msg(16'd1234);
    wait_done("done_after_rst", 400);

    repeat (3) @(negedge clk);
    #1;
    check("done_pulse_count", done_cnt, n_msgs);
    check("queue_empty_at_end", exp_q.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/result_ascii_sender.md
RESULT_ASCII_SENDER -- requirements
Module: result_ascii_sender

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning the unsigned result width (legal range 1..16); the output is always at most 5 decimal digits.
REQ-002 SHALL have port clk  input  1  system clock; all logic is on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port value  input  DATA_W  unsigned binary result, sampled only on an accepted start.
REQ-005 SHALL have port start  input  1  single-cycle request to send value.
REQ-006 SHALL have port tx_rts  input  1  serial transmitter ready: high = idle, low = frame in progress.
REQ-007 SHALL have port tx_data  output  8  ASCII byte presented to the serial transmitter.
REQ-008 SHALL have port tx_data_ready  output  1  one-cycle byte-launch strobe to the serial transmitter.
REQ-009 SHALL have port busy  output  1  high from the accepted start until done.
REQ-010 SHALL have port done  output  1  one-cycle pulse after the last byte's frame completes.

Function
REQ-011 SHALL accept start only in IDLE; a start while busy is ignored and value is not resampled.
REQ-012 SHALL capture value on the accepted start and assert busy on the next cycle.
REQ-013 SHALL convert value to 5 BCD digits by sequential shift-add-3 (double dabble), taking exactly DATA_W cycles in state CONVERT.
REQ-014 SHALL suppress leading zeros; value 0 SHALL emit the single digit "0" (0x30).
REQ-015 SHALL encode each digit as 0x30 + BCD, most significant digit first.
REQ-016 SHALL use the states IDLE -> CONVERT -> LOAD -> PULSE -> WAIT_BUSY -> WAIT_DONE -> (LOAD for the next byte | FINISH) -> IDLE.
REQ-017 LOAD SHALL set tx_data to the current byte; tx_data SHALL stay stable from LOAD until WAIT_DONE exits.
REQ-018 PULSE SHALL wait for tx_rts=1, then drive tx_data_ready high for exactly one cycle.
REQ-019 tx_data_ready SHALL never be high for two consecutive cycles.
REQ-020 WAIT_BUSY SHALL hold until tx_rts=0; tx_rts still high on the cycle after the strobe SHALL NOT cause a re-strobe.
REQ-021 WAIT_DONE SHALL hold until tx_rts=1, then advance to the next byte.
REQ-022 There SHALL be no timeout; tx_rts stuck low stalls the block indefinitely with busy=1.
REQ-023 FINISH SHALL pulse done for one cycle and deassert busy on the same cycle.
REQ-024 A start arriving in the same cycle as done SHALL be ignored; a start one cycle later SHALL be accepted.
REQ-025 An in-range value SHALL produce 1..5 digit bytes plus the terminator bytes of REQ-031; bits of value beyond DATA_W do not exist.

Reset
REQ-026 Asserting rst SHALL immediately force: state IDLE, tx_data=0x00, tx_data_ready=0, busy=0, done=0, BCD and digit counters cleared.
REQ-027 Reset mid-operation SHALL abandon the message with no further strobes.
REQ-028 The first strobe after reset SHALL still wait for tx_rts=1, so a frame already in progress completes undisturbed.
REQ-029 Deassertion of rst SHALL take effect on the next rising clk edge; no start is accepted before then.

Configuration
REQ-030 The macro RESULT_CRLF_EN SHALL select the message terminator.
REQ-031 With RESULT_CRLF_EN defined, the digits SHALL be followed by 0x0D then 0x0A, each sent with the same handshake as the digits.
REQ-032 Without RESULT_CRLF_EN, the message SHALL end after the last digit and done SHALL follow that byte's WAIT_DONE.

Verification
REQ-033 With RESULT_CRLF_EN, value=1234 and an ideal transmitter model -> bytes 0x31,0x32,0x33,0x34,0x0D,0x0A, then one done pulse.
REQ-034 With RESULT_CRLF_EN, value=0 -> 0x30,0x0D,0x0A; value=65535 (DATA_W=16) -> 0x36,0x35,0x35,0x33,0x35,0x0D,0x0A.
REQ-035 tx_rts held low for 1000 cycles after start -> tx_data_ready stays 0 and busy stays 1; releasing tx_rts -> first byte strobed within 2 cycles.
REQ-036 Second start (value=7) pulsed mid-message of value=1234 -> ignored, exactly the 1234 bytes sent; start one cycle after done -> 0x37 sent.
REQ-037 rst pulsed during the third byte of 1234 -> all outputs 0 within the reset cycle, no further strobes, and the next start sends a complete, correct message.
REQ-038 Without RESULT_CRLF_EN, value=1234 -> exactly 4 bytes 0x31..0x34, then done.
